// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the four-state (K=3) Viterbi traceback stage.
// Trellis state s = {newest input bit, previous input bit}.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int STATE_W    = 2;

  typedef enum logic [1:0] {
    COLLECT,
    TRACE,
    EMIT
  } fsm_state_t;

  // The survivor decision picks the older input bit that was shifted out.
  function automatic logic [STATE_W-1:0] predecessor(input logic [STATE_W-1:0] state,
                                                      input logic d);
    return {state[0], d};
  endfunction

  function automatic logic decoded_bit(input logic [STATE_W-1:0] state);
    return state[1];
  endfunction

endpackage

// File: rtl/tb_dec_ram.sv
// Survivor decision store: synchronous write, combinational read so that a
// full traceback step (read + predecessor select) completes in one cycle.
module tb_dec_ram
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [LEN_W-1:0]      i_waddr,
  input  logic [NUM_STATES-1:0] i_wdata,
  input  logic [LEN_W-1:0]      i_raddr,
  output logic [NUM_STATES-1:0] o_rdata
);

  logic [NUM_STATES-1:0] r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Frame-based survivor memory and traceback: collect decisions, trace back
// from the end state one step per cycle, then stream bits oldest-first.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_STATES-1:0] in_dec,
  input  logic                  in_last,
  input  logic [STATE_W-1:0]    in_end_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last,
  output logic                  err_overflow
);

  localparam int LEN_W = $clog2(MAX_LEN);

  fsm_state_t            r_state;
  fsm_state_t            w_state_next;
  logic [LEN_W-1:0]      r_wr_idx;
  logic [LEN_W:0]        r_n;
  logic [STATE_W-1:0]    r_cur;
  logic [LEN_W-1:0]      r_tr_idx;
  logic [LEN_W-1:0]      r_rd_idx;
  logic                  r_err;
  logic [MAX_LEN-1:0]    r_bitbuf;
  logic [NUM_STATES-1:0] w_rd_dec;
  logic                  w_in_fire;
  logic                  w_frame_end;
  logic                  w_out_fire;
  logic                  w_last_rd;

  assign w_in_fire   = in_valid && (r_state == COLLECT);
  assign w_frame_end = in_last || (r_wr_idx == LEN_W'(MAX_LEN - 1));
  assign w_last_rd   = ({1'b0, r_rd_idx} == (r_n - (LEN_W + 1)'(1)));
  assign w_out_fire  = (r_state == EMIT) && out_ready;

  tb_dec_ram #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_dec_ram (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_waddr (r_wr_idx),
    .i_wdata (in_dec),
    .i_raddr (r_tr_idx),
    .o_rdata (w_rd_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_in_fire && w_frame_end) w_state_next = TRACE;
      TRACE:   if (r_tr_idx == '0) w_state_next = EMIT;
      EMIT:    if (w_out_fire && w_last_rd) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx <= '0;
      r_n      <= '0;
      r_cur    <= '0;
      r_tr_idx <= '0;
      r_rd_idx <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_in_fire) begin
            if (w_frame_end) begin
              // A forced end has no end-state hint; the encoder is assumed flushed to 00.
              r_wr_idx <= '0;
              r_n      <= {1'b0, r_wr_idx} + (LEN_W + 1)'(1);
              r_tr_idx <= r_wr_idx;
              r_cur    <= in_last ? in_end_state : '0;
              if (!in_last) r_err <= 1'b1;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end
        TRACE: begin
          r_cur    <= predecessor(r_cur, w_rd_dec[r_cur]);
          r_tr_idx <= r_tr_idx - 1'b1;
          r_rd_idx <= '0;
        end
        EMIT: begin
          if (w_out_fire) r_rd_idx <= r_rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bits are recovered newest-first but stored by step index for oldest-first output.
  always_ff @(posedge clk) begin
    if (r_state == TRACE) begin
      r_bitbuf[r_tr_idx] <= decoded_bit(r_cur);
    end
  end

  assign in_ready     = (r_state == COLLECT);
  assign out_valid    = (r_state == EMIT);
  assign out_bit      = (r_state == EMIT) && r_bitbuf[r_rd_idx];
  assign out_last     = (r_state == EMIT) && w_last_rd;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: hand-computed frames, backpressure,
// overflow, mid-operation reset and the single-step frame.
module tb_viterbi_traceback;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_dec;
  logic       in_last;
  logic [1:0] in_end_state;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       err_overflow;

  int checks   = 0;
  int failures = 0;

  logic [3:0] vec [0:31];
  logic       exp_bits [0:31];
  logic [1:0] es;

  viterbi_traceback #(.MAX_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dec       (in_dec),
    .in_last      (in_last),
    .in_end_state (in_end_state),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .out_last     (out_last),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_zero_vec();
    for (int k = 0; k < 32; k++) begin
      vec[k] = 4'b0000;
      exp_bits[k] = 1'b0;
    end
  endtask

  task automatic set_known_path();
    vec[0] = 4'b0000; vec[1] = 4'b0000; vec[2] = 4'b0100;
    vec[3] = 4'b0000; vec[4] = 4'b0010; vec[5] = 4'b0001;
    exp_bits[0] = 1'b1; exp_bits[1] = 1'b0; exp_bits[2] = 1'b1;
    exp_bits[3] = 1'b1; exp_bits[4] = 1'b0; exp_bits[5] = 1'b0;
    es = 2'b00;
  endtask

  task automatic send(input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      in_valid     = 1'b1;
      in_dec       = vec[k];
      in_last      = with_last && (k == n - 1);
      in_end_state = es;
      chk("send_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expects out_valid exactly n cycles after the observation point following the last beat.
  task automatic recv(input int n, input bit bp, input bit hold);
    int cyc;
    int i;
    cyc = 0;
    if (hold) begin
      in_valid = 1'b1; in_dec = 4'hF; in_last = 1'b1;
    end
    out_ready = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (hold) chk("trace_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, n);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 400) begin
      out_ready = (bp && (cyc % 4 == 1 || cyc % 4 == 2)) ? 1'b0 : 1'b1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_bit", {31'd0, out_bit}, {31'd0, exp_bits[i]});
      chk("out_last", {31'd0, out_last}, (i == n - 1) ? 32'd1 : 32'd0);
      if (hold) chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("recv_count", i, n);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dec = 4'h0; in_last = 1'b0;
    in_end_state = 2'b00; out_ready = 1'b1; es = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_err", {31'd0, err_overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("step: zero frame N=4");
    set_zero_vec(); es = 2'b00;
    send(4, 1'b1);
    recv(4, 1'b0, 1'b0);

    $display("step: known path N=6");
    set_known_path();
    send(6, 1'b1);
    recv(6, 1'b0, 1'b0);
    chk("known_err", {31'd0, err_overflow}, 32'd0);

    $display("step: known path with backpressure");
    set_known_path();
    send(6, 1'b1);
    recv(6, 1'b1, 1'b1);

    $display("step: single-step frame end state 10");
    set_zero_vec(); es = 2'b10; exp_bits[0] = 1'b1;
    send(1, 1'b1);
    recv(1, 1'b0, 1'b0);

    $display("step: overflow at 32 beats without in_last");
    set_zero_vec(); es = 2'b11;
    send(32, 1'b0);
    chk("ovf_err_set", {31'd0, err_overflow}, 32'd1);
    recv(32, 1'b0, 1'b1);
    send(8, 1'b0);
    send(23, 1'b0);
    chk("ovf_next_pending", {31'd0, out_valid}, 32'd0);
    chk("ovf_next_in_ready", {31'd0, in_ready}, 32'd1);
    send(1, 1'b0);
    recv(32, 1'b0, 1'b0);
    chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);

    $display("step: reset during trace");
    set_known_path();
    send(6, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_err", {31'd0, err_overflow}, 32'd0);
    chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    set_zero_vec(); es = 2'b00;
    send(4, 1'b1);
    recv(4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Survivor-memory and traceback stage directly downstream of the four-state add-compare-select array of the rate-1/2, K=3 Viterbi decoder.
- Each accepted input is one trellis step: a 4-bit vector with one survivor decision bit per state.
- Operates frame by frame. It stores decisions until the frame ends, traces back from the known end state, then streams the decoded bits out oldest-first over a valid/ready handshake.

Parameters:
- MAX_LEN, 32, maximum trellis steps per frame; must be a power of two, at least 2.
- LEN_W, $clog2(MAX_LEN), width of step index/counters (derived, not overridden).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_dec/in_last/in_end_state valid this cycle.
- in_ready  output  1  block accepts input; transfer when in_valid && in_ready.
- in_dec  input  4  decision per state s (bit s): survivor predecessor of s is {s[0], in_dec[s]}.
- in_last  input  1  final step of frame.
- in_end_state  input  2  traceback start state; sampled only on the accepted in_last beat.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out_bit  output  1  decoded bit.
- out_last  output  1  marks final decoded bit of frame.
- err_overflow  output  1  sticky; set when a frame is force-terminated at MAX_LEN; cleared only by rst.

Behaviour:
- Trellis convention:
  - State s = {newest input bit, previous input bit}; next state = {u, s[1]}.
  - Decoded bit for a step whose state is s = s[1].
  - Predecessor of s = {s[0], d}.
- Reset (async, any state, including mid-TRACE/EMIT):
  - FSM returns to COLLECT; write index is 0.
  - in_ready=1, out_valid=0, out_bit=0, out_last=0, err_overflow=0.
  - Partial frame is discarded; memory contents are don't-care.
- COLLECT:
  - in_ready=1, out_valid=0.
  - On each accepted beat: mem[wr_idx] <= in_dec, wr_idx++.
  - If in_last, or wr_idx == MAX_LEN-1 on the accepted beat:
    - latch N = wr_idx+1;
    - latch end state (in_end_state if in_last, else 2'b00);
    - go TRACE.
  - Forced end without in_last sets err_overflow. The next beat starts a new frame.
- TRACE:
  - in_ready=0 (in_valid ignored).
  - One step per cycle, idx from N-1 down to 0, with cur starting at the end state:
    - bitbuf[idx] <= cur[1];
    - cur <= {cur[0], mem[idx][cur]};
    - after idx 0 go EMIT.
  - Exactly N cycles.
- EMIT:
  - in_ready=0; out_valid=1.
  - out_bit = bitbuf[rd_idx] with rd_idx from 0 up; out_last = (rd_idx == N-1).
  - rd_idx advances only on a handshake; outputs are held stable while out_ready=0.
  - Handshake on out_last returns to COLLECT with wr_idx=0, and in_ready=1 on the next cycle.
- Latency:
  - in_last accepted in cycle T → TRACE in T+1..T+N → out_valid first high in T+N+1.
  - Minimum frame N=1.
- Widths: wr_idx/rd_idx/trace idx are LEN_W bits; N is stored as LEN_W+1 bits. There is no wrap-around within a frame.
- Storage: decisions MAX_LEN×4 and bitbuf MAX_LEN×1, both register arrays.

Decomposition:
- Package viterbi_pkg:
  - NUM_STATES=4, STATE_W=2;
  - the FSM state enum (COLLECT, TRACE, EMIT);
  - function predecessor(state, d) returning {state[0], d};
  - function decoded_bit(state).
- One sub-module, tb_dec_ram:
  - MAX_LEN×4 register array;
  - synchronous write, combinational read, so that one trace step completes per cycle.

Test Plan:
- Zero frame: 4 beats in_dec=4'b0000, last on 4th, in_end_state=0, out_ready=1 → out_bit 0,0,0,0; out_last on 4th; first out_valid exactly 5 cycles after last beat.
- Known path: in_dec = 0000, 0000, 0100, 0000, 0010, 0001 (last), in_end_state=00 → out_bit 1,0,1,1,0,0; out_last on 6th; err_overflow=0.
- Backpressure: repeat the known path with out_ready toggled 1,0,0,1,… → each bit held stable while out_ready=0; sequence and out_last unchanged; in_ready=0 throughout TRACE/EMIT with in_valid held high and no beats consumed.
- Overflow: MAX_LEN=32, 40 beats with in_last never asserted and all-zero decisions:
  - frame forced at beat 32, err_overflow=1, end state 00;
  - 32 zero bits with out_last on the 32nd;
  - remaining 8 beats form the next frame once in_ready returns.
- Reset mid-operation: assert rst during TRACE of a 6-step frame → immediately out_valid=0, in_ready=1, err_overflow=0; a fresh zero frame afterwards decodes correctly.
- Single-step frame: one beat in_dec=4'b0000, in_last=1, in_end_state=2'b10 → one out_bit=1 with out_last=1, out_valid rising 2 cycles after the beat.
